// File: rtl/anemo_sample_ring_master.sv
// Avalon-MM master storing 32-bit anemometer samples into a circular buffer
// held in on-chip RAM, with indexed read-back (index 0 = oldest sample).
module anemo_sample_ring_master #(
   parameter int unsigned ADDR_W       = 13,
   parameter int unsigned DEPTH        = 5000,
   parameter int unsigned BASE_WORD    = 0,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sample_valid,
   input  logic [31:0]       sample_data,
   output logic              sample_ready,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_index,
   output logic              rd_ready,
   output logic [31:0]       rd_data,
   output logic              rd_valid,
   output logic              rd_err,
   input  logic              clear,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic [ADDR_W-1:0] m_address,
   output logic [3:0]        m_byteenable,
   output logic              m_chipselect,
   output logic              m_write,
   output logic              m_read,
   output logic [31:0]       m_writedata,
   input  logic [31:0]       m_readdata,
   input  logic              m_waitrequest
);

   typedef enum logic [1:0] {IDLE, WRITE, READ_ISSUE, READ_WAIT} state_t;

   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_C   = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_WORD);
   localparam logic [1:0]        LAT_INIT = 2'(READ_LATENCY - 1);

   state_t              state_q, state_d;
   logic                hold_full_q, hold_full_d;
   logic [31:0]         hold_data_q, hold_data_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic                wrapped_q, wrapped_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                clear_pend_q, clear_pend_d;
   logic                rd_pend_q, rd_pend_d;
   logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
   logic [1:0]          lat_q, lat_d;
   logic [ADDR_W-1:0]   m_address_q, m_address_d;
   logic                m_write_q, m_write_d;
   logic                m_read_q, m_read_d;
   logic                m_cs_q, m_cs_d;
   logic [31:0]         m_writedata_q, m_writedata_d;
   logic [31:0]         rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                rd_err_q, rd_err_d;
   logic                sample_ready_q, sample_ready_d;
   logic                rd_ready_q, rd_ready_d;

   logic                s_acc, r_acc;
   logic [ADDR_W-1:0]   oldest;
   logic [ADDR_W-1:0]   idx;
   logic [ADDR_W:0]     sum_w;
   logic [ADDR_W-1:0]   slot;
   logic                in_range;

   // Ring slot for the requested age index; a request latched behind a write
   // is evaluated against the ring state after that write has completed.
   always_comb begin
      oldest   = wrapped_q ? wr_ptr_q : '0;
      idx      = rd_pend_q ? rd_idx_q : rd_index;
      sum_w    = {1'b0, oldest} + {1'b0, idx};
      slot     = ADDR_W'((sum_w >= DEPTH_C) ? (sum_w - DEPTH_C) : sum_w);
      in_range = ({1'b0, idx} < count_q);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d        = state_q;
      hold_full_d    = hold_full_q;
      hold_data_d    = hold_data_q;
      wr_ptr_d       = wr_ptr_q;
      wrapped_d      = wrapped_q;
      count_d        = count_q;
      overflow_d     = overflow_q;
      clear_pend_d   = clear_pend_q | clear;
      rd_pend_d      = rd_pend_q;
      rd_idx_d       = rd_idx_q;
      lat_d          = lat_q;
      m_address_d    = m_address_q;
      m_write_d      = m_write_q;
      m_read_d       = m_read_q;
      m_writedata_d  = m_writedata_q;
      rd_data_d      = rd_data_q;
      rd_valid_d     = 1'b0;
      rd_err_d       = 1'b0;

      s_acc = sample_valid & sample_ready_q;
      r_acc = rd_req & rd_ready_q;

      if (s_acc) begin
         hold_full_d = 1'b1;
         hold_data_d = sample_data;
      end
      // A read taken in the same cycle as a sample is parked until the write is done.
      if (r_acc) begin
         rd_pend_d = 1'b1;
         rd_idx_d  = rd_index;
      end

      unique case (state_q)
         IDLE: begin
            if (clear_pend_q) begin
               wr_ptr_d     = '0;
               count_d      = '0;
               wrapped_d    = 1'b0;
               overflow_d   = 1'b0;
               clear_pend_d = clear;
            end else if (hold_full_q || s_acc) begin
               state_d       = WRITE;
               m_write_d     = 1'b1;
               m_address_d   = BASE_C + wr_ptr_q;
               m_writedata_d = hold_full_q ? hold_data_q : sample_data;
            end else if (rd_pend_q || r_acc) begin
               rd_pend_d = 1'b0;
               if (in_range) begin
                  state_d     = READ_ISSUE;
                  m_read_d    = 1'b1;
                  m_address_d = BASE_C + slot;
               end else begin
                  rd_valid_d = 1'b1;
                  rd_err_d   = 1'b1;
                  rd_data_d  = '0;
               end
            end
         end
         WRITE: begin
            if (!m_waitrequest) begin
               m_write_d   = 1'b0;
               hold_full_d = 1'b0;
               state_d     = IDLE;
               if (wr_ptr_q == LAST_C) begin
                  wr_ptr_d  = '0;
                  wrapped_d = 1'b1;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
               if (count_q == DEPTH_C) begin
                  overflow_d = 1'b1;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         READ_ISSUE: begin
            if (!m_waitrequest) begin
               m_read_d = 1'b0;
               lat_d    = LAT_INIT;
               state_d  = READ_WAIT;
            end
         end
         READ_WAIT: begin
            if (lat_q == 2'd0) begin
               rd_data_d  = m_readdata;
               rd_valid_d = 1'b1;
               state_d    = IDLE;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      m_cs_d         = m_write_d | m_read_d;
      sample_ready_d = ~hold_full_d;
      rd_ready_d     = (state_d == IDLE) & ~hold_full_d & ~clear_pend_d & ~rd_pend_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         hold_full_q    <= 1'b0;
         hold_data_q    <= '0;
         wr_ptr_q       <= '0;
         wrapped_q      <= 1'b0;
         count_q        <= '0;
         overflow_q     <= 1'b0;
         clear_pend_q   <= 1'b0;
         rd_pend_q      <= 1'b0;
         rd_idx_q       <= '0;
         lat_q          <= '0;
         m_address_q    <= '0;
         m_write_q      <= 1'b0;
         m_read_q       <= 1'b0;
         m_cs_q         <= 1'b0;
         m_writedata_q  <= '0;
         rd_data_q      <= '0;
         rd_valid_q     <= 1'b0;
         rd_err_q       <= 1'b0;
         sample_ready_q <= 1'b1;
         rd_ready_q     <= 1'b1;
      end else begin
         state_q        <= state_d;
         hold_full_q    <= hold_full_d;
         hold_data_q    <= hold_data_d;
         wr_ptr_q       <= wr_ptr_d;
         wrapped_q      <= wrapped_d;
         count_q        <= count_d;
         overflow_q     <= overflow_d;
         clear_pend_q   <= clear_pend_d;
         rd_pend_q      <= rd_pend_d;
         rd_idx_q       <= rd_idx_d;
         lat_q          <= lat_d;
         m_address_q    <= m_address_d;
         m_write_q      <= m_write_d;
         m_read_q       <= m_read_d;
         m_cs_q         <= m_cs_d;
         m_writedata_q  <= m_writedata_d;
         rd_data_q      <= rd_data_d;
         rd_valid_q     <= rd_valid_d;
         rd_err_q       <= rd_err_d;
         sample_ready_q <= sample_ready_d;
         rd_ready_q     <= rd_ready_d;
      end
   end

   assign sample_ready = sample_ready_q;
   assign rd_ready     = rd_ready_q;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign rd_err       = rd_err_q;
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign m_address    = m_address_q;
   assign m_byteenable = {4{m_cs_q}};
   assign m_chipselect = m_cs_q;
   assign m_write      = m_write_q;
   assign m_read       = m_read_q;
   assign m_writedata  = m_writedata_q;

endmodule

// File: tb/tb_anemo_sample_ring_master.sv
// Directed bench for anemo_sample_ring_master: DEPTH=8, READ_LATENCY=2,
// with a small on-chip RAM slave model honouring waitrequest and latency.
module tb_anemo_sample_ring_master;

   localparam int unsigned AW = 13;
   localparam int unsigned RL = 2;

   logic          clk;
   logic          reset_n;
   logic          sample_valid;
   logic [31:0]   sample_data;
   logic          sample_ready;
   logic          rd_req;
   logic [AW-1:0] rd_index;
   logic          rd_ready;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic          rd_err;
   logic          clear;
   logic [AW:0]   count;
   logic          overflow;
   logic [AW-1:0] m_address;
   logic [3:0]    m_byteenable;
   logic          m_chipselect;
   logic          m_write;
   logic          m_read;
   logic [31:0]   m_writedata;
   logic [31:0]   m_readdata;
   logic          m_waitrequest;

   int checks = 0;
   int errors = 0;

   anemo_sample_ring_master #(
      .ADDR_W(AW), .DEPTH(8), .BASE_WORD(0), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
      .rd_req(rd_req), .rd_index(rd_index), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
      .clear(clear), .count(count), .overflow(overflow),
      .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
      .m_write(m_write), .m_read(m_read), .m_writedata(m_writedata),
      .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM slave model with a two-stage read pipeline
   logic [31:0] mem [0:(1<<AW)-1];
   logic [31:0] pipe0, pipe1;
   logic [AW-1:0] wlog_addr [$];
   logic [31:0]   wlog_data [$];
   logic [3:0]    wlog_be [$];
   int rd_acc_cnt = 0;
   int rd_strobe_cycles = 0;

   assign m_readdata = pipe1;

   always @(posedge clk) begin
      if (m_write && m_chipselect && !m_waitrequest) begin
         mem[m_address] <= m_writedata;
         wlog_addr.push_back(m_address);
         wlog_data.push_back(m_writedata);
         wlog_be.push_back(m_byteenable);
      end
      if (m_read) rd_strobe_cycles++;
      if (m_read && m_chipselect && !m_waitrequest) begin
         rd_acc_cnt++;
         pipe0 <= mem[m_address];
      end else begin
         pipe0 <= 32'hDEAD_BEEF;
      end
      pipe1 <= pipe0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d);
      int n;
      n = 0;
      while (!sample_ready && n < 50) begin tick(); n++; end
      chk("push_ready", {31'd0, sample_ready}, 32'd1);
      sample_valid = 1'b1;
      sample_data  = d;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      int k;
      k = 1;
      while (!rd_valid && k < 50) begin tick(); k++; end
      chk("rd_valid_seen", {31'd0, rd_valid}, 32'd1);
      lat = k;
   endtask

   task automatic do_read(input logic [AW-1:0] i, output logic [31:0] d,
                          output logic e, output int lat);
      int n;
      n = 0;
      while (!rd_ready && n < 50) begin tick(); n++; end
      chk("rd_ready_wait", {31'd0, rd_ready}, 32'd1);
      rd_req   = 1'b1;
      rd_index = i;
      tick();
      rd_req = 1'b0;
      wait_valid(lat);
      d = rd_data;
      e = rd_err;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        e;
      int          lat;
      int          base_wr, base_rd, base_strobe;

      reset_n = 1'b1; sample_valid = 1'b0; sample_data = '0;
      rd_req = 1'b0; rd_index = '0; clear = 1'b0; m_waitrequest = 1'b0;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sample_ready", {31'd0, sample_ready}, 32'd1);
      chk("rst_rd_ready", {31'd0, rd_ready}, 32'd1);
      chk("rst_count", {18'd0, count}, 32'd0);
      chk("rst_strobes", {28'd0, m_write, m_read, m_chipselect, rd_valid}, 32'd0);
      chk("rst_be", {28'd0, m_byteenable}, 32'd0);
      reset_n = 1'b1;
      tick();

      // Three samples to addresses 0..2
      push(32'h11);
      chk("write_strobe_n1", {30'd0, m_write, m_chipselect}, 32'd3);
      push(32'h22);
      push(32'h33);
      tick();
      chk("count3", {18'd0, count}, 32'd3);
      chk("wlog_size3", wlog_addr.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk("wlog_addr", {19'd0, wlog_addr[i]}, i);
         chk("wlog_be", {28'd0, wlog_be[i]}, 32'hF);
      end
      chk("wlog_data1", wlog_data[1], 32'h22);

      // Indexed read with latency RL+2
      do_read(1, d, e, lat);
      chk("rd1_data", d, 32'h22);
      chk("rd1_err", {31'd0, e}, 32'd0);
      chk("rd1_latency", lat, RL + 2);

      // Out-of-range index: error pulse, no bus read
      base_strobe = rd_strobe_cycles;
      do_read(3, d, e, lat);
      chk("rderr_flag", {31'd0, e}, 32'd1);
      chk("rderr_data", d, 32'd0);
      chk("rderr_latency", lat, 1);
      tick();
      chk("rderr_no_mread", rd_strobe_cycles - base_strobe, 32'd0);

      // Write stalled by waitrequest for 5 cycles
      m_waitrequest = 1'b1;
      base_wr = wlog_addr.size();
      push(32'h44);
      for (int i = 0; i < 5; i++) begin
         chk("wstall_strobes", {29'd0, m_write, m_chipselect, sample_ready}, 32'd6);
         chk("wstall_addr", {19'd0, m_address}, 32'd3);
         chk("wstall_data", m_writedata, 32'h44);
         tick();
      end
      chk("wstall_nolog", wlog_addr.size() - base_wr, 32'd0);
      m_waitrequest = 1'b0;
      tick();
      chk("wstall_one_write", wlog_addr.size() - base_wr, 32'd1);
      chk("wstall_count", {18'd0, count}, 32'd4);
      chk("wstall_m_write_off", {31'd0, m_write}, 32'd0);

      // Read stalled by waitrequest for 5 cycles
      base_rd = rd_acc_cnt;
      m_waitrequest = 1'b1;
      rd_req = 1'b1; rd_index = 3;
      tick();
      rd_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("rstall_strobes", {30'd0, m_read, m_chipselect}, 32'd3);
         chk("rstall_addr", {19'd0, m_address}, 32'd3);
         tick();
      end
      m_waitrequest = 1'b0;
      wait_valid(lat);
      chk("rstall_data", rd_data, 32'h44);
      chk("rstall_one_read", rd_acc_cnt - base_rd, 32'd1);

      // Sample and read request in the same cycle: write first
      while (!(rd_ready && sample_ready)) tick();
      sample_valid = 1'b1; sample_data = 32'h55;
      rd_req = 1'b1; rd_index = 4;
      tick();
      sample_valid = 1'b0; rd_req = 1'b0;
      chk("same_rd_ready_low", {31'd0, rd_ready}, 32'd0);
      chk("same_write_first", {30'd0, m_write, m_read}, 32'd2);
      wait_valid(lat);
      chk("same_data", rd_data, 32'h55);
      chk("same_err", {31'd0, rd_err}, 32'd0);
      chk("same_count", {18'd0, count}, 32'd5);

      // Clear during READ_WAIT: read completes, then ring empties
      while (!rd_ready) tick();
      rd_req = 1'b1; rd_index = 0;
      tick();
      rd_req = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      wait_valid(lat);
      chk("clr_rd_data", rd_data, 32'h11);
      chk("clr_rd_err", {31'd0, rd_err}, 32'd0);
      tick();
      chk("clr_count", {18'd0, count}, 32'd0);

      // Ten samples into a ring of eight
      for (int i = 1; i <= 8; i++) push(i);
      tick();
      chk("ovf_count8", {18'd0, count}, 32'd8);
      chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
      push(9);
      push(10);
      tick();
      chk("ovf_count_sat", {18'd0, count}, 32'd8);
      chk("ovf_flag", {31'd0, overflow}, 32'd1);
      chk("ovf_last_addr", {19'd0, wlog_addr[wlog_addr.size()-1]}, 32'd1);
      do_read(0, d, e, lat);
      chk("ovf_rd0", d, 32'd3);
      do_read(7, d, e, lat);
      chk("ovf_rd7", d, 32'd10);
      do_read(8, d, e, lat);
      chk("ovf_rd8_err", {31'd0, e}, 32'd1);

      // Asynchronous reset in the middle of a stalled write
      m_waitrequest = 1'b1;
      base_wr = wlog_addr.size();
      push(32'h77);
      tick();
      chk("mid_write_active", {31'd0, m_write}, 32'd1);
      #3 reset_n = 1'b0;
      #1;
      chk("async_strobes", {29'd0, m_write, m_read, m_chipselect}, 32'd0);
      chk("async_count", {18'd0, count}, 32'd0);
      chk("async_overflow", {31'd0, overflow}, 32'd0);
      chk("async_sample_ready", {31'd0, sample_ready}, 32'd1);
      m_waitrequest = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      chk("async_no_write", wlog_addr.size() - base_wr, 32'd0);
      push(32'hAA);
      tick();
      chk("post_rst_addr", {19'd0, wlog_addr[wlog_addr.size()-1]}, 32'd0);
      chk("post_rst_count", {18'd0, count}, 32'd1);
      do_read(0, d, e, lat);
      chk("post_rst_rd", d, 32'hAA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
